// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU compressed-port issuer.
package fir_xifu_pkg;

    // Storage width for the hart ID in the request buffer; HARTID_W must not exceed it.
    localparam int unsigned XIF_HARTID_MAX_W = 32;

    typedef enum logic [1:0] {
        CmpIdle = 2'd0,
        CmpReq  = 2'd1,
        CmpHold = 2'd2
    } fir_xifu_cmp_state_e;

    typedef struct packed {
        logic [15:0]                 instr;
        logic [XIF_HARTID_MAX_W-1:0] hartid;
    } fir_xifu_cmp_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        accept;
    } fir_xifu_cmp_res_t;

    // A rejected compressed instruction is passed on zero-extended.
    function automatic logic [31:0] fir_xifu_zext16(input logic [15:0] x);
        return {16'h0000, x};
    endfunction

endpackage

// File: rtl/fir_xifu_sat_cnt.sv
// Saturating up-counter with asynchronous active-high reset.
module fir_xifu_sat_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    // Count increments, holding at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fir_xifu_cmp_issuer.sv
// Core-side initiator for the XIF compressed interface.
// Optional statistics counters are enabled by defining FIR_XIFU_CMP_STATS_EN.
module fir_xifu_cmp_issuer
    import fir_xifu_pkg::*;
#(
    parameter int unsigned HARTID_W = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic [15:0]         instr_i,
    input  logic [HARTID_W-1:0] hartid_i,
    output logic                compressed_valid_o,
    input  logic                compressed_ready_i,
    output logic [15:0]         compressed_instr_o,
    output logic [HARTID_W-1:0] compressed_hartid_o,
    input  logic                compressed_accept_i,
    input  logic [31:0]         compressed_resp_instr_i,
    output logic                dec_valid_o,
    input  logic                dec_ready_i,
    output logic [31:0]         dec_instr_o,
    output logic                dec_accept_o,
    output logic [CNT_W-1:0]    accept_cnt_o,
    output logic [CNT_W-1:0]    reject_cnt_o
);

    fir_xifu_cmp_state_e r_state, w_state_d;
    fir_xifu_cmp_req_t   r_req, w_req_d;
    fir_xifu_cmp_res_t   r_res, w_res_d;
    logic                r_kill, w_kill_d;

    logic w_ready;
    logic w_up_hs;
    logic w_xif_hs;
    logic w_done;

    // Handshake decode; ready is held low during reset so every output reads 0 then.
    always_comb begin
        w_ready  = ~rst_i & ~flush_i &
                   ((r_state == CmpIdle) | ((r_state == CmpHold) & dec_ready_i));
        w_up_hs  = instr_valid_i & w_ready;
        w_xif_hs = (r_state == CmpReq) & compressed_ready_i;
        // A killed request, or one flushed in its own handshake cycle, produces no result.
        w_done   = w_xif_hs & ~r_kill & ~flush_i;
    end

    // Next-state, request buffer, result capture and kill flag.
    always_comb begin
        w_state_d = r_state;
        w_req_d   = r_req;
        w_res_d   = r_res;
        w_kill_d  = r_kill;

        if (w_up_hs) begin
            w_req_d.instr  = instr_i;
            w_req_d.hartid = XIF_HARTID_MAX_W'(hartid_i);
        end

        unique case (r_state)
            CmpIdle: begin
                if (w_up_hs) w_state_d = CmpReq;
            end
            CmpReq: begin
                if (w_xif_hs) begin
                    w_kill_d = 1'b0;
                    if (w_done) begin
                        w_res_d.accept = compressed_accept_i;
                        w_res_d.instr  = compressed_accept_i ? compressed_resp_instr_i
                                                             : fir_xifu_zext16(r_req.instr);
                        w_state_d      = CmpHold;
                    end else begin
                        w_state_d = CmpIdle;
                    end
                end else if (flush_i) begin
                    // The request cannot be retracted; remember to drop its response.
                    w_kill_d = 1'b1;
                end
            end
            CmpHold: begin
                if (flush_i) begin
                    w_state_d = CmpIdle;
                end else if (dec_ready_i) begin
                    w_state_d = w_up_hs ? CmpReq : CmpIdle;
                end
            end
            default: begin
                w_state_d = CmpIdle;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= CmpIdle;
            r_req   <= '0;
            r_res   <= '0;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_req   <= w_req_d;
            r_res   <= w_res_d;
            r_kill  <= w_kill_d;
        end
    end

    assign instr_ready_o       = w_ready;
    assign compressed_valid_o  = (r_state == CmpReq);
    assign compressed_instr_o  = r_req.instr;
    assign compressed_hartid_o = HARTID_W'(r_req.hartid);
    assign dec_valid_o         = (r_state == CmpHold);
    assign dec_instr_o         = r_res.instr;
    assign dec_accept_o        = r_res.accept;

`ifdef FIR_XIFU_CMP_STATS_EN
    fir_xifu_sat_cnt #(
        .WIDTH(CNT_W)
    ) u_accept_cnt (
        .i_clk(clk_i),
        .i_rst(rst_i),
        .i_inc(w_done & compressed_accept_i),
        .o_cnt(accept_cnt_o)
    );

    fir_xifu_sat_cnt #(
        .WIDTH(CNT_W)
    ) u_reject_cnt (
        .i_clk(clk_i),
        .i_rst(rst_i),
        .i_inc(w_done & ~compressed_accept_i),
        .o_cnt(reject_cnt_o)
    );
`else
    assign accept_cnt_o = {CNT_W{1'b0}};
    assign reject_cnt_o = {CNT_W{1'b0}};
`endif

endmodule
